// File: rtl/id_retire_sequencer_pkg.sv
// Shared types and sizing for the in-order retire sequencer.
package id_retire_sequencer_pkg;

   localparam int unsigned MAX_IDS        = 8;
   localparam int unsigned COMMIT_PORTS   = 2;
   localparam int unsigned NUM_WB_SOURCES = 3;

   localparam int unsigned ID_W  = $clog2(MAX_IDS);
   localparam int unsigned CNT_W = ID_W + 1;
   localparam int unsigned RC_W  = $clog2(COMMIT_PORTS) + 1;

   typedef logic [ID_W-1:0]  id_t;
   typedef logic [CNT_W-1:0] cnt_t;
   typedef logic [RC_W-1:0]  rc_t;

   typedef struct packed {
      id_t  id;
      logic valid;
   } retire_packet_t;

endpackage

// File: rtl/id_retire_sequencer_if.sv
// Issue / writeback / retire bundle between the pipeline and the retire sequencer.
interface id_retire_sequencer_if;
   import id_retire_sequencer_pkg::*;

   logic                      flush;
   logic                      issue_valid;
   id_t                       issue_id;
   logic [NUM_WB_SOURCES-1:0] wb_valid;
   id_t  [NUM_WB_SOURCES-1:0] wb_id;
   logic [COMMIT_PORTS-1:0]   retired;
   id_t  [COMMIT_PORTS-1:0]   ids_retiring;
   rc_t                       retire_count;
   logic                      queue_full;
   logic                      queue_empty;

   modport master (
      output flush, issue_valid, issue_id, wb_valid, wb_id,
      input  retired, ids_retiring, retire_count, queue_full, queue_empty
   );

   modport slave (
      input  flush, issue_valid, issue_id, wb_valid, wb_id,
      output retired, ids_retiring, retire_count, queue_full, queue_empty
   );

endinterface

// File: rtl/id_retire_sequencer_id_fifo_ram.sv
// Circular ID queue: one write port at tail, COMMIT_PORTS read ports at head+k.
module id_fifo_ram
   import id_retire_sequencer_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic we,
   input  id_t  waddr,
   input  id_t  wdata,
   input  id_t  raddr,
   output id_t  rdata [COMMIT_PORTS]
);

   id_t mem [MAX_IDS];

   // Reset keeps the read ports deterministic before the first enqueue.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(MAX_IDS); i++) mem[i] <= '0;
      end else if (we) begin
         mem[waddr] <= wdata;
      end
   end

   always_comb begin
      for (int k = 0; k < int'(COMMIT_PORTS); k++) rdata[k] = mem[raddr + ID_W'(k)];
   end

endmodule

// File: rtl/id_retire_sequencer.sv
// In-order retire sequencer: tracks completion per ID and retires up to
// COMMIT_PORTS IDs per cycle in program order.
module id_retire_sequencer
   import id_retire_sequencer_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst_n,
   id_retire_sequencer_if.slave  bus
);

   id_t                     head;
   id_t                     tail;
   cnt_t                    count;
   logic [MAX_IDS-1:0]      done;
   logic [MAX_IDS-1:0]      pending;

   id_t                     slot_id [COMMIT_PORTS];
   retire_packet_t          pkt     [COMMIT_PORTS];
   logic [COMMIT_PORTS-1:0] retired_c;
   rc_t                     retire_count_c;
   logic                    chain;
   logic                    enq;
   logic [MAX_IDS-1:0]      wb_mask;
   logic [MAX_IDS-1:0]      enq_mask;
   logic [MAX_IDS-1:0]      ret_mask;
   logic [NUM_WB_SOURCES-1:0] wb_bad;

   assign enq = bus.issue_valid & ~bus.flush;

   id_fifo_ram u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (enq),
      .waddr (tail),
      .wdata (bus.issue_id),
      .raddr (head),
      .rdata (slot_id)
   );

   // Retire chain: a port fires only if every older port fires too.
   always_comb begin
      chain          = 1'b1;
      retired_c      = '0;
      retire_count_c = '0;
      ret_mask       = '0;
      for (int k = 0; k < int'(COMMIT_PORTS); k++) begin
         pkt[k].id    = slot_id[k];
         pkt[k].valid = chain & (CNT_W'(k) < count) & done[slot_id[k]] & ~bus.flush;
         chain        = pkt[k].valid;
         retired_c[k] = pkt[k].valid;
         retire_count_c = retire_count_c + RC_W'(pkt[k].valid);
         if (pkt[k].valid) ret_mask[slot_id[k]] = 1'b1;
      end
   end

   always_comb begin
      wb_mask  = '0;
      enq_mask = '0;
      wb_bad   = '0;
      if (enq) enq_mask[bus.issue_id] = 1'b1;
      for (int s = 0; s < int'(NUM_WB_SOURCES); s++) begin
         if (bus.wb_valid[s]) begin
            wb_mask[bus.wb_id[s]] = 1'b1;
            wb_bad[s] = ~bus.flush &
                        (~pending[bus.wb_id[s]] | (enq & (bus.wb_id[s] == bus.issue_id)));
         end
      end
   end

   // Enqueue clear is applied after completion set so it wins on a collision.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head    <= '0;
         tail    <= '0;
         count   <= '0;
         done    <= '0;
         pending <= '0;
      end else if (bus.flush) begin
         head    <= tail;
         count   <= '0;
         done    <= '0;
         pending <= '0;
      end else begin
         tail    <= tail + ID_W'(enq);
         head    <= head + ID_W'(retire_count_c);
         count   <= count + CNT_W'(enq) - CNT_W'(retire_count_c);
         done    <= (done | wb_mask) & ~enq_mask;
         pending <= (pending & ~ret_mask) | enq_mask;
      end
   end

   always_comb begin
      bus.retired      = retired_c;
      bus.retire_count = retire_count_c;
      for (int k = 0; k < int'(COMMIT_PORTS); k++) bus.ids_retiring[k] = slot_id[k];
      bus.queue_full   = (count == CNT_W'(MAX_IDS));
      bus.queue_empty  = (count == '0);
   end

   a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
      !(enq && bus.queue_full && (retire_count_c == '0)));

   a_wb_legal: assert property (@(posedge clk) disable iff (!rst_n)
      (wb_bad == '0));

   a_retired_known: assert property (@(posedge clk) disable iff (!rst_n)
      !$isunknown(retired_c));

endmodule

// File: tb/tb_id_retire_sequencer.sv
// Directed and random checks of id_retire_sequencer against a queue-based reference model.
module tb_id_retire_sequencer;
   import id_retire_sequencer_pkg::*;

   logic clk;
   logic rst_n;
   int   compared;
   int   mismatched;

   int   q[$];
   bit   done_m [MAX_IDS];

   id_retire_sequencer_if bus();

   id_retire_sequencer dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input bit f, input bit iv, input int iid,
                        input bit [2:0] wv, input int w0, input int w1, input int w2);
      bus.flush       = f;
      bus.issue_valid = iv;
      bus.issue_id    = id_t'(iid);
      bus.wb_valid    = wv;
      bus.wb_id[0]    = id_t'(w0);
      bus.wb_id[1]    = id_t'(w1);
      bus.wb_id[2]    = id_t'(w2);
   endtask

   task automatic idle();
      drive(1'b0, 1'b0, 0, 3'b000, 0, 0, 0);
   endtask

   task automatic model_reset();
      q.delete();
      for (int i = 0; i < int'(MAX_IDS); i++) done_m[i] = 1'b0;
   endtask

   // Checks outputs for the current inputs, then advances the model over one clock edge.
   task automatic cycle();
      int n;
      logic [31:0] exp_ret;
      #1;
      n = 0;
      if (!bus.flush)
         while (n < int'(COMMIT_PORTS) && n < q.size() && done_m[q[n]]) n++;
      exp_ret = (32'd1 << n) - 32'd1;
      check("retired", 32'(bus.retired), exp_ret);
      check("retire_count", 32'(bus.retire_count), 32'(n));
      for (int k = 0; k < n; k++) check("ids_retiring", 32'(bus.ids_retiring[k]), 32'(q[k]));
      check("queue_full", 32'(bus.queue_full), 32'(q.size() == int'(MAX_IDS)));
      check("queue_empty", 32'(bus.queue_empty), 32'(q.size() == 0));
      @(posedge clk);
      if (bus.flush) begin
         model_reset();
      end else begin
         for (int k = 0; k < n; k++) void'(q.pop_front());
         for (int s = 0; s < int'(NUM_WB_SOURCES); s++)
            if (bus.wb_valid[s]) done_m[int'(bus.wb_id[s])] = 1'b1;
         if (bus.issue_valid) begin
            q.push_back(int'(bus.issue_id));
            done_m[int'(bus.issue_id)] = 1'b0;
         end
      end
      #1;
   endtask

   task automatic random_step();
      bit inq [MAX_IDS];
      int free_ids[$];
      bit iv;
      int iid;
      bit [2:0] wv;
      int w [3];
      for (int i = 0; i < int'(MAX_IDS); i++) inq[i] = 1'b0;
      foreach (q[i]) inq[q[i]] = 1'b1;
      for (int i = 0; i < int'(MAX_IDS); i++) if (!inq[i]) free_ids.push_back(i);
      iv  = 1'b0;
      iid = 0;
      if (free_ids.size() > 0 && $urandom_range(0, 2) != 0) begin
         iv  = 1'b1;
         iid = free_ids[$urandom_range(0, free_ids.size() - 1)];
      end
      wv = 3'b000;
      for (int s = 0; s < 3; s++) begin
         w[s] = 0;
         if (q.size() > 0 && $urandom_range(0, 1) == 1) begin
            wv[s] = 1'b1;
            w[s]  = q[$urandom_range(0, q.size() - 1)];
         end
      end
      drive($urandom_range(0, 39) == 0, iv, iid, wv, w[0], w[1], w[2]);
      cycle();
   endtask

   initial begin
      compared   = 0;
      mismatched = 0;
      rst_n      = 1'b0;
      idle();
      model_reset();
      #1;
      check("rst_retired", 32'(bus.retired), 32'd0);
      check("rst_retire_count", 32'(bus.retire_count), 32'd0);
      check("rst_queue_empty", 32'(bus.queue_empty), 32'd1);
      check("rst_queue_full", 32'(bus.queue_full), 32'd0);
      check("rst_ids_retiring0", 32'(bus.ids_retiring[0]), 32'd0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      cycle();

      // Out-of-order completion of 3,4,5
      drive(0, 1, 3, 3'b000, 0, 0, 0); cycle();
      drive(0, 1, 4, 3'b000, 0, 0, 0); cycle();
      drive(0, 1, 5, 3'b000, 0, 0, 0); cycle();
      drive(0, 0, 0, 3'b001, 5, 0, 0); cycle();
      drive(0, 0, 0, 3'b001, 4, 0, 0); cycle();
      drive(0, 0, 0, 3'b001, 3, 0, 0); cycle();
      idle(); #1;
      check("t2_pair_retired", 32'(bus.retired), 32'd3);
      check("t2_pair_id1", 32'(bus.ids_retiring[1]), 32'd4);
      cycle(); cycle();
      check("t2_empty", 32'(bus.queue_empty), 32'd1);

      // Fill, complete everything, drain two per cycle across the wrap
      for (int i = 0; i < 8; i++) begin
         drive(0, 1, i, 3'b000, 0, 0, 0);
         cycle();
      end
      idle();
      check("t3_full", 32'(bus.queue_full), 32'd1);
      drive(0, 0, 0, 3'b111, 7, 6, 5); cycle();
      drive(0, 0, 0, 3'b111, 4, 3, 2); cycle();
      drive(0, 0, 0, 3'b011, 1, 0, 0); cycle();
      idle();
      for (int i = 0; i < 4; i++) begin
         check("t3_rc2", 32'(bus.retire_count), 32'd2);
         check("t3_id0", 32'(bus.ids_retiring[0]), 32'(2 * i));
         cycle();
      end
      check("t3_empty", 32'(bus.queue_empty), 32'd1);

      // Enqueue and retire in the same cycle at count 3
      drive(0, 1, 0, 3'b000, 0, 0, 0); cycle();
      drive(0, 1, 1, 3'b000, 0, 0, 0); cycle();
      drive(0, 1, 2, 3'b001, 0, 0, 0); cycle();
      drive(0, 1, 3, 3'b000, 0, 0, 0); cycle();
      idle();
      check("t4_count3_not_full", 32'(bus.queue_full), 32'd0);
      check("t4_queue_len", 32'(q.size()), 32'd3);
      drive(1, 0, 0, 3'b000, 0, 0, 0); cycle();

      // Flush drops a same-cycle completion; re-enqueued ID needs a fresh wb
      drive(0, 1, 2, 3'b000, 0, 0, 0); cycle();
      drive(0, 1, 6, 3'b000, 0, 0, 0); cycle();
      drive(1, 0, 0, 3'b001, 2, 0, 0); cycle();
      idle();
      check("t5_empty_after_flush", 32'(bus.queue_empty), 32'd1);
      drive(0, 1, 2, 3'b000, 0, 0, 0); cycle();
      idle(); cycle(); cycle();
      drive(0, 0, 0, 3'b001, 2, 0, 0); cycle();
      idle();
      check("t5_fresh_wb_retires", 32'(bus.retired), 32'd1);
      cycle();

      // Younger completion waits on the older one
      drive(0, 1, 1, 3'b000, 0, 0, 0); cycle();
      drive(0, 1, 2, 3'b000, 0, 0, 0); cycle();
      drive(0, 0, 0, 3'b001, 2, 0, 0); cycle();
      idle();
      repeat (10) cycle();
      drive(0, 0, 0, 3'b001, 1, 0, 0); cycle();
      idle();
      check("t6_both_retire", 32'(bus.retired), 32'd3);
      check("t6_port1_id", 32'(bus.ids_retiring[1]), 32'd2);
      cycle();

      repeat (400) random_step();
      drive(1, 0, 0, 3'b000, 0, 0, 0); cycle();

      // Asynchronous reset with completed entries about to retire
      drive(0, 1, 1, 3'b000, 0, 0, 0); cycle();
      drive(0, 1, 2, 3'b000, 0, 0, 0); cycle();
      drive(0, 0, 0, 3'b011, 1, 2, 0); cycle();
      idle();
      rst_n = 1'b0;
      #1;
      model_reset();
      check("t1_rst_retired", 32'(bus.retired), 32'd0);
      check("t1_rst_retire_count", 32'(bus.retire_count), 32'd0);
      check("t1_rst_empty", 32'(bus.queue_empty), 32'd1);
      check("t1_rst_full", 32'(bus.queue_full), 32'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (4) cycle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
